// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline (load-use, redirect, dmem wait, MDU).
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall/redirect performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       decode_i_rs1,
  input  logic [4:0]       decode_i_rs2,
  input  logic             decode_i_rs1_ren,
  input  logic             decode_i_rs2_ren,
  input  logic             regE_i_mem_ren,
  input  logic [4:0]       regE_i_wb_rd,
  input  logic             execute_i_redirect,
  input  logic             execute_i_mdu_req,
  input  logic             execute_i_mdu_done,
  input  logic             regM_i_mem_req,
  input  logic             mem_i_ready,
  output logic             ctrl_o_mdu_start,
  output logic             ctrl_o_regF_stall,
  output logic             ctrl_o_regD_stall,
  output logic             ctrl_o_regE_stall,
  output logic             ctrl_o_regM_stall,
  output logic             ctrl_o_regD_flush,
  output logic             ctrl_o_regE_flush,
  output logic             ctrl_o_regM_flush,
  output logic             ctrl_o_regW_flush,
  output logic             ctrl_o_timeout,
  output logic [CNT_W-1:0] ctrl_o_stall_cnt,
  output logic [CNT_W-1:0] ctrl_o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2,
    MDU_HOLD = 2'd3
  } state_e;

  // Timer value at which the next stalled cycle completes MEM_TIMEOUT-1 waits.
  localparam logic [CNT_W-1:0] TMO_ARM = CNT_W'(MEM_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] TMR_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic             mem_stall_s;
  logic             mdu_busy_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             load_use_s;

  // Hazard detection
  always_comb begin
    mem_stall_s = regM_i_mem_req & ~mem_i_ready;
    mdu_busy_s  = (((state_q == RUN) & execute_i_mdu_req) | (state_q == MDU_WAIT))
                  & ~execute_i_mdu_done;
    rs1_hit_s   = decode_i_rs1_ren & (decode_i_rs1 == regE_i_wb_rd);
    rs2_hit_s   = decode_i_rs2_ren & (decode_i_rs2 == regE_i_wb_rd);
    load_use_s  = regE_i_mem_ren & (regE_i_wb_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
  end

  // Prioritised stall/flush decode; reset loads bubbles into D..W
  always_comb begin
    ctrl_o_mdu_start  = 1'b0;
    ctrl_o_regF_stall = 1'b0;
    ctrl_o_regD_stall = 1'b0;
    ctrl_o_regE_stall = 1'b0;
    ctrl_o_regM_stall = 1'b0;
    ctrl_o_regD_flush = 1'b0;
    ctrl_o_regE_flush = 1'b0;
    ctrl_o_regM_flush = 1'b0;
    ctrl_o_regW_flush = 1'b0;
    if (!rst_n) begin
      ctrl_o_regD_flush = 1'b1;
      ctrl_o_regE_flush = 1'b1;
      ctrl_o_regM_flush = 1'b1;
      ctrl_o_regW_flush = 1'b1;
    end else if (mem_stall_s) begin
      ctrl_o_regF_stall = 1'b1;
      ctrl_o_regD_stall = 1'b1;
      ctrl_o_regE_stall = 1'b1;
      ctrl_o_regM_stall = 1'b1;
      ctrl_o_regW_flush = 1'b1;
    end else if (mdu_busy_s) begin
      ctrl_o_regF_stall = 1'b1;
      ctrl_o_regD_stall = 1'b1;
      ctrl_o_regE_stall = 1'b1;
      ctrl_o_regM_flush = 1'b1;
      ctrl_o_mdu_start  = (state_q == RUN);
    end else if (execute_i_redirect) begin
      // Fetch is redirected, so F keeps moving.
      ctrl_o_regD_flush = 1'b1;
      ctrl_o_regE_flush = 1'b1;
    end else if (load_use_s) begin
      ctrl_o_regF_stall = 1'b1;
      ctrl_o_regD_stall = 1'b1;
      ctrl_o_regE_flush = 1'b1;
    end else begin
      ctrl_o_mdu_start  = 1'b0;
    end
  end

  // Wait-state FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          state_d = MEM_WAIT;
        end else if (execute_i_mdu_req & ~execute_i_mdu_done) begin
          state_d = MDU_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_i_ready) begin
          state_d = RUN;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      MDU_WAIT: begin
        // A result arriving under a memory stall is parked until memory frees.
        if (execute_i_mdu_done) begin
          state_d = mem_stall_s ? MDU_HOLD : RUN;
        end else begin
          state_d = MDU_WAIT;
        end
      end
      MDU_HOLD: begin
        if (!mem_stall_s) begin
          state_d = RUN;
        end else begin
          state_d = MDU_HOLD;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating memory-wait timer and sticky timeout
  always_comb begin
    if (!mem_stall_s) begin
      timer_d = '0;
    end else if (timer_q != TMR_MAX) begin
      timer_d = timer_q + CNT_W'(1);
    end else begin
      timer_d = timer_q;
    end
    timeout_d = timeout_q | (mem_stall_s & (timer_q >= TMO_ARM));
  end

  // State, timer and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign ctrl_o_timeout = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_any_s;
  logic             redirect_win_s;

  // Counter increments; any stall output is set exactly in these cases out of reset
  always_comb begin
    stall_any_s    = mem_stall_s | mdu_busy_s | (load_use_s & ~execute_i_redirect);
    redirect_win_s = execute_i_redirect & ~mem_stall_s & ~mdu_busy_s;
    if (stall_any_s) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_win_s) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Wrapping performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl_o_stall_cnt = stall_cnt_q;
  assign ctrl_o_flush_cnt = flush_cnt_q;
`else
  assign ctrl_o_stall_cnt = '0;
  assign ctrl_o_flush_cnt = '0;
`endif

endmodule
